// File: rtl/uva_transmit_deser.sv
// rtl/uva_transmit_deser.sv - single-clock serial-to-parallel receiver with framing,
// valid/ready output slot, completed-word counter and sticky overflow flag.
module uva_transmit_deser #(
  parameter int WORD_W    = 4,
  parameter int CNT_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_100Mz,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              data_pack,
  input  logic              sinhr,
  input  logic              stop,
  input  logic              word_ready,
  input  logic              clr_ovf,
  output logic [WORD_W-1:0] tran_data,
  output logic              word_valid,
  output logic [CNT_W-1:0]  cnt_check_data,
  output logic              overflow,
  output logic              running
);

  localparam int BW = $clog2(WORD_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] tran_data_q, tran_data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              word_done;
  logic              slot_free;

  // Shifted image including the current bit; it is also the completed word.
  logic [WORD_W-1:0] shift_next;
  assign shift_next = MSB_FIRST ? {shift_q[WORD_W-2:0], data_pack}
                                : {data_pack, shift_q[WORD_W-1:1]};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sinhr) begin
          state_d   = RUN;
          bit_cnt_d = bit_en ? BW'(1) : '0;
        end
      end
      RUN: begin
        if (bit_en) begin
          if (bit_cnt_q == BW'(WORD_W - 1)) begin
            word_done = !(sinhr && !stop);
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        if (stop) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sinhr) begin
          bit_cnt_d = bit_en ? BW'(1) : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d     = bit_en ? shift_next : shift_q;
    slot_free   = !valid_q || word_ready;
    tran_data_d = tran_data_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q + CNT_W'(word_done);
    if (word_done && slot_free) begin
      tran_data_d = shift_next;
      valid_d     = 1'b1;
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    // A drop in the same cycle as clr_ovf leaves the flag set.
    if (word_done && !slot_free) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tran_data_q <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tran_data_q <= tran_data_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tran_data      = tran_data_q;
  assign word_valid     = valid_q;
  assign cnt_check_data = cnt_q;
  assign overflow       = ovf_q;
  assign running        = (state_q == RUN);

endmodule

// File: tb/tb_uva_transmit_deser.sv
// tb/tb_uva_transmit_deser.sv - directed table and sequence checks for uva_transmit_deser
// using three instances (MSB-first, LSB-first, 3-bit counter) on shared stimulus.
module tb_uva_transmit_deser;

  logic clk = 1'b0;
  logic rst, bit_en, data_pack, sinhr, stop, word_ready, clr_ovf;

  logic [3:0]  data_a, data_b, data_c;
  logic        vld_a, vld_b, vld_c;
  logic [15:0] cnt_a, cnt_b;
  logic [2:0]  cnt_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        run_a, run_b, run_c;

  always #5 clk = ~clk;

  uva_transmit_deser #(.WORD_W(4), .CNT_W(16), .MSB_FIRST(1'b1)) dut_a (
    .clk_100Mz(clk), .rst(rst), .bit_en(bit_en), .data_pack(data_pack), .sinhr(sinhr),
    .stop(stop), .word_ready(word_ready), .clr_ovf(clr_ovf), .tran_data(data_a),
    .word_valid(vld_a), .cnt_check_data(cnt_a), .overflow(ovf_a), .running(run_a));

  uva_transmit_deser #(.WORD_W(4), .CNT_W(16), .MSB_FIRST(1'b0)) dut_b (
    .clk_100Mz(clk), .rst(rst), .bit_en(bit_en), .data_pack(data_pack), .sinhr(sinhr),
    .stop(stop), .word_ready(word_ready), .clr_ovf(clr_ovf), .tran_data(data_b),
    .word_valid(vld_b), .cnt_check_data(cnt_b), .overflow(ovf_b), .running(run_b));

  uva_transmit_deser #(.WORD_W(4), .CNT_W(3), .MSB_FIRST(1'b1)) dut_c (
    .clk_100Mz(clk), .rst(rst), .bit_en(bit_en), .data_pack(data_pack), .sinhr(sinhr),
    .stop(stop), .word_ready(word_ready), .clr_ovf(clr_ovf), .tran_data(data_c),
    .word_valid(vld_c), .cnt_check_data(cnt_c), .overflow(ovf_c), .running(run_c));

  typedef struct {
    logic s, e, d, p, r, c;
    logic run, vld;
    logic [3:0] da, db;
    logic [15:0] cnt;
    logic ovf;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, e, d, p, r, c, input logic run, vld,
                     input logic [3:0] da, db, input logic [15:0] cnt, input logic ovf);
    vec_t v;
    v.s = s; v.e = e; v.d = d; v.p = p; v.r = r; v.c = c;
    v.run = run; v.vld = vld; v.da = da; v.db = db; v.cnt = cnt; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic step(input logic s, e, d, p, r, c);
    sinhr = s; bit_en = e; data_pack = d; stop = p; word_ready = r; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bit_en = 0; data_pack = 0; sinhr = 0; stop = 0; word_ready = 0; clr_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", data_a, 4'h0);
    chk("reset_valid", vld_a, 1'b0);
    chk("reset_cnt", cnt_a, 16'd0);
    chk("reset_ovf_run", {ovf_a, run_a}, 2'b00);
    rst = 1'b0;

    // basic capture, bits 1,0,1,1, consumer ready
    add(1,1,1,0,1,0, 1,0,4'h0,4'h0,0,0);
    add(0,1,0,0,1,0, 1,0,4'h0,4'h0,0,0);
    add(0,1,1,0,1,0, 1,0,4'h0,4'h0,0,0);
    add(0,1,1,0,1,0, 1,1,4'hB,4'hD,1,0);
    add(0,0,0,0,1,0, 1,0,4'hB,4'hD,1,0);
    // word A with bit_en every 4th clock; toggling data in gaps must not matter
    for (int i = 0; i < 4; i++) begin
      add(0,1,(i % 2 == 0),0,0,0, 1,(i == 3),(i == 3) ? 4'hA : 4'hB,
          (i == 3) ? 4'h5 : 4'hD,(i == 3) ? 16'd2 : 16'd1,0);
      if (i < 3)
        for (int g = 0; g < 3; g++)
          add(0,0,g[0],0,0,0, 1,0,4'hB,4'hD,1,0);
    end
    // word 5 into an occupied slot is dropped
    add(0,1,0,0,0,0, 1,1,4'hA,4'h5,2,0);
    add(0,1,1,0,0,0, 1,1,4'hA,4'h5,2,0);
    add(0,1,0,0,0,0, 1,1,4'hA,4'h5,2,0);
    add(0,1,1,0,0,0, 1,1,4'hA,4'h5,3,1);
    add(0,0,0,0,0,1, 1,1,4'hA,4'h5,3,0);
    add(0,0,0,0,1,0, 1,0,4'hA,4'h5,3,0);
    // word F held, then accept and load in the same cycle
    add(0,1,1,0,0,0, 1,0,4'hA,4'h5,3,0);
    add(0,1,1,0,0,0, 1,0,4'hA,4'h5,3,0);
    add(0,1,1,0,0,0, 1,0,4'hA,4'h5,3,0);
    add(0,1,1,0,0,0, 1,1,4'hF,4'hF,4,0);
    add(0,1,0,0,0,0, 1,1,4'hF,4'hF,4,0);
    add(0,1,0,0,0,0, 1,1,4'hF,4'hF,4,0);
    add(0,1,1,0,0,0, 1,1,4'hF,4'hF,4,0);
    add(0,1,1,0,1,0, 1,1,4'h3,4'hC,5,0);
    // drop coinciding with clr_ovf: set wins
    add(0,1,0,0,0,0, 1,1,4'h3,4'hC,5,0);
    add(0,1,0,0,0,0, 1,1,4'h3,4'hC,5,0);
    add(0,1,0,0,0,0, 1,1,4'h3,4'hC,5,0);
    add(0,1,0,0,0,1, 1,1,4'h3,4'hC,6,1);
    add(0,0,0,0,1,1, 1,0,4'h3,4'hC,6,0);

    foreach (tbl[k]) begin
      step(tbl[k].s, tbl[k].e, tbl[k].d, tbl[k].p, tbl[k].r, tbl[k].c);
      chk($sformatf("v%0d_run", k), run_a, tbl[k].run);
      chk($sformatf("v%0d_valid", k), vld_a, tbl[k].vld);
      chk($sformatf("v%0d_data_msb", k), data_a, tbl[k].da);
      chk($sformatf("v%0d_data_lsb", k), data_b, tbl[k].db);
      chk($sformatf("v%0d_cnt", k), cnt_a, tbl[k].cnt);
      chk($sformatf("v%0d_ovf", k), ovf_a, tbl[k].ovf);
    end

    // re-alignment: two bits, then sinhr restarts the word
    step(0,1,1,0,1,0);
    step(0,1,1,0,1,0);
    step(1,1,1,0,1,0);
    chk("realign_no_word", {vld_a, run_a}, 2'b01);
    step(0,1,0,0,1,0);
    step(0,1,1,0,1,0);
    chk("realign_pending", vld_a, 1'b0);
    step(0,1,0,0,1,0);
    chk("realign_word", {vld_a, data_a, data_b}, {1'b1, 4'hA, 4'h5});
    chk("realign_cnt", cnt_a, 16'd7);

    // stop after 3 bits: no word, back to IDLE, later bits ignored
    step(0,1,1,0,1,0);
    step(0,1,0,0,1,0);
    step(0,1,1,0,1,0);
    step(0,0,0,1,1,0);
    chk("stop_idle", {run_a, vld_a}, 2'b00);
    for (int i = 0; i < 5; i++) step(0,1,1,0,1,0);
    chk("stop_no_word", {vld_a, run_a, cnt_a}, {2'b00, 16'd7});

    // word completing with stop is still delivered
    step(1,1,1,0,1,0);
    step(0,1,1,0,1,0);
    step(0,1,0,0,1,0);
    step(0,1,0,1,1,0);
    chk("stop_complete", {run_a, vld_a, data_a, cnt_a}, {2'b01, 4'hC, 16'd8});
    step(0,0,0,0,1,0);
    chk("stop_accepted", vld_a, 1'b0);

    // reset mid-word with a held word in the slot
    step(1,1,1,0,0,0);
    step(0,1,1,0,0,0);
    step(0,1,1,0,0,0);
    step(0,1,1,0,0,0);
    step(0,1,1,0,0,0);
    step(0,1,1,0,0,0);
    chk("pre_reset_hold", {vld_a, data_a}, {1'b1, 4'hF});
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {data_a, vld_a, cnt_a, ovf_a, run_a}, 23'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) step(0,1,1,0,1,0);
    chk("post_reset_quiet", {vld_a, run_a, cnt_a}, 18'd0);

    // 9 words into the 3-bit counter instance
    for (int w = 0; w < 9; w++) begin
      for (int b = 0; b < 4; b++) step((w == 0 && b == 0), 1, (b != 1), 0, 1, 0);
      if (w == 7) chk("wrap_8_words", cnt_c, 3'd0);
    end
    chk("wrap_9_words", cnt_c, 3'd1);
    chk("wide_cnt_9", cnt_a, 16'd9);
    chk("wrap_last_word", {vld_c, data_c}, {1'b1, 4'hB});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
